// File: rtl/pipeline_stall_sequencer_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// State encodings double as the State_OUT debug value.
package pipeline_stall_sequencer_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN     = 2'd0,
    ST_MULDIV  = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_SERVICE = 2'd3
  } state_e;

  // Pipeline-register controls that can ever be non-zero
  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic flush_ifid;
    logic stall_idexe;
    logic flush_idexe;
    logic flush_exemem;
  } stall_ctrl_t;

  localparam stall_ctrl_t CTRL_NONE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam stall_ctrl_t CTRL_MULDIV  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam stall_ctrl_t CTRL_SYSCALL = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam stall_ctrl_t CTRL_LOADUSE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam stall_ctrl_t CTRL_BRANCH  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  // Forces every control low while the pipeline is held in reset
  function automatic stall_ctrl_t gate_ctrl(stall_ctrl_t c, logic en);
    return en ? c : CTRL_NONE;
  endfunction

endpackage

// File: rtl/pipeline_stall_sequencer_if.sv
// Hazard request / stall control bundle between the hazard detectors and the sequencer.
interface pipeline_stall_sequencer_if;
  import pipeline_stall_sequencer_pkg::*;

  logic               Syscall_IN;
  logic               LoadUse_IN;
  logic               Branch_Taken_IN;
  logic               MulDiv_Start_IN;
  logic               Syscall_Done_IN;

  logic               STALL_PC;
  logic               STALL_IFID;
  logic               FLUSH_IFID;
  logic               STALL_IDEXE;
  logic               FLUSH_IDEXE;
  logic               STALL_EXEMEM;
  logic               FLUSH_EXEMEM;
  logic               STALL_MEMWB;
  logic               FLUSH_MEMWB;
  logic               Syscall_OUT;
  logic [STATE_W-1:0] State_OUT;

  modport master (
    output Syscall_IN, LoadUse_IN, Branch_Taken_IN, MulDiv_Start_IN, Syscall_Done_IN,
    input  STALL_PC, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE,
           STALL_EXEMEM, FLUSH_EXEMEM, STALL_MEMWB, FLUSH_MEMWB, Syscall_OUT, State_OUT
  );

  modport slave (
    input  Syscall_IN, LoadUse_IN, Branch_Taken_IN, MulDiv_Start_IN, Syscall_Done_IN,
    output STALL_PC, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE,
           STALL_EXEMEM, FLUSH_EXEMEM, STALL_MEMWB, FLUSH_MEMWB, Syscall_OUT, State_OUT
  );

endinterface

// File: rtl/pipeline_stall_sequencer_cycle_down_counter.sv
// Loadable saturating down-counter shared by the mult/div and syscall-drain phases.
// is_one_o is registered alongside the count so the FSM sees a clean flag.
module pipeline_stall_sequencer_cycle_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_one_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             is_one_q;

  // Load wins over decrement; decrement stops at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      is_one_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      is_one_q <= (count_d == WIDTH'(1));
    end
  end

  assign is_one_o = is_one_q;

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Stall/flush controls are Mealy so a hazard stalls in the cycle it is raised.
module pipeline_stall_sequencer
  import pipeline_stall_sequencer_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned DRAIN_DEPTH   = 3
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  pipeline_stall_sequencer_if.slave  bus
);

  // Start cycle is spent in RUN, so MULDIV itself lasts two cycles fewer than the op
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_DEPTH);

  state_e           state_q, state_d;
  logic             syscall_out_q, syscall_out_d;
  stall_ctrl_t      ctrl_c;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0] cnt_load_val;

  pipeline_stall_sequencer_cycle_down_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_down_counter (
    .clk        (CLOCK),
    .rst_n      (RESET),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .is_one_o   (cnt_is_one)
  );

  always_comb begin
    state_d      = state_q;
    ctrl_c       = CTRL_NONE;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.MulDiv_Start_IN) begin
          ctrl_c       = CTRL_MULDIV;
          cnt_load     = 1'b1;
          cnt_load_val = MULDIV_LOAD;
          state_d      = ST_MULDIV;
        end else if (bus.Syscall_IN) begin
          ctrl_c       = CTRL_SYSCALL;
          cnt_load     = 1'b1;
          cnt_load_val = DRAIN_LOAD;
          state_d      = ST_DRAIN;
        end else if (bus.LoadUse_IN) begin
          ctrl_c = CTRL_LOADUSE;
        end else if (bus.Branch_Taken_IN) begin
          ctrl_c = CTRL_BRANCH;
        end
      end
      ST_MULDIV: begin
        ctrl_c  = CTRL_MULDIV;
        cnt_dec = 1'b1;
        if (cnt_is_one) state_d = ST_RUN;
      end
      ST_DRAIN: begin
        ctrl_c  = CTRL_SYSCALL;
        cnt_dec = 1'b1;
        if (cnt_is_one) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        ctrl_c = CTRL_SYSCALL;
        if (bus.Syscall_Done_IN) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pulse only on the DRAIN->SERVICE transition
  assign syscall_out_d = (state_q == ST_DRAIN) && cnt_is_one;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_RUN;
      syscall_out_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      syscall_out_q <= syscall_out_d;
    end
  end

  stall_ctrl_t ctrl_gated;
  assign ctrl_gated = gate_ctrl(ctrl_c, RESET);

  assign bus.STALL_PC     = ctrl_gated.stall_pc;
  assign bus.STALL_IFID   = ctrl_gated.stall_ifid;
  assign bus.FLUSH_IFID   = ctrl_gated.flush_ifid;
  assign bus.STALL_IDEXE  = ctrl_gated.stall_idexe;
  assign bus.FLUSH_IDEXE  = ctrl_gated.flush_idexe;
  assign bus.STALL_EXEMEM = 1'b0;
  assign bus.FLUSH_EXEMEM = ctrl_gated.flush_exemem;
  assign bus.STALL_MEMWB  = 1'b0;
  assign bus.FLUSH_MEMWB  = 1'b0;
  assign bus.Syscall_OUT  = syscall_out_q;
  assign bus.State_OUT    = state_q;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Bench for pipeline_stall_sequencer: directed scenarios with literal expectations,
// then random hazard traffic checked every cycle against a remaining-cycles model.
module tb_pipeline_stall_sequencer;

  localparam int unsigned MULDIV_CYCLES = 4;
  localparam int unsigned DRAIN_DEPTH   = 3;

  // Output vector: {PC, IFID_s, IFID_f, IDEXE_s, IDEXE_f, EXEMEM_s, EXEMEM_f, MEMWB_s, MEMWB_f, SysOut, State[1:0]}
  localparam logic [11:0] O_NONE = 12'h000;
  localparam logic [11:0] O_MD   = 12'hD20;
  localparam logic [11:0] O_SC   = 12'hA00;
  localparam logic [11:0] O_LU   = 12'hC80;
  localparam logic [11:0] O_BR   = 12'h200;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;

  pipeline_stall_sequencer_if bus ();

  pipeline_stall_sequencer #(
    .MULDIV_CYCLES (MULDIV_CYCLES),
    .DRAIN_DEPTH   (DRAIN_DEPTH)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int n_vec = 0;
  int n_err = 0;

  // Model: cycles left in each multi-cycle phase
  int   md_left    = 0;
  int   dr_left    = 0;
  logic in_service = 1'b0;
  logic pulse      = 1'b0;

  function automatic logic [11:0] model_out();
    logic [11:0] o;
    o = O_NONE;
    if (md_left > 0) begin
      o = O_MD | 12'd1;
    end else if (dr_left > 0) begin
      o = O_SC | 12'd2;
    end else if (in_service) begin
      o = O_SC | 12'd3;
    end else if (bus.MulDiv_Start_IN) begin
      o = O_MD;
    end else if (bus.Syscall_IN) begin
      o = O_SC;
    end else if (bus.LoadUse_IN) begin
      o = O_LU;
    end else if (bus.Branch_Taken_IN) begin
      o = O_BR;
    end
    if (pulse) o = o | 12'h004;
    if (!RESET) o = O_NONE;
    return o;
  endfunction

  function automatic logic [11:0] dut_out();
    return {bus.STALL_PC, bus.STALL_IFID, bus.FLUSH_IFID, bus.STALL_IDEXE, bus.FLUSH_IDEXE,
            bus.STALL_EXEMEM, bus.FLUSH_EXEMEM, bus.STALL_MEMWB, bus.FLUSH_MEMWB,
            bus.Syscall_OUT, bus.State_OUT};
  endfunction

  always @(posedge CLOCK) begin
    if (!RESET) begin
      md_left = 0; dr_left = 0; in_service = 1'b0; pulse = 1'b0;
    end else if (md_left > 0) begin
      md_left = md_left - 1;
    end else if (dr_left > 0) begin
      dr_left = dr_left - 1;
      if (dr_left == 0) begin
        in_service = 1'b1;
        pulse      = 1'b1;
      end
    end else if (in_service) begin
      pulse = 1'b0;
      if (bus.Syscall_Done_IN) in_service = 1'b0;
    end else if (bus.MulDiv_Start_IN) begin
      md_left = int'(MULDIV_CYCLES) - 2;
    end else if (bus.Syscall_IN) begin
      dr_left = int'(DRAIN_DEPTH);
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge CLOCK) begin
    logic [11:0] exp_v, got_v;
    #1;
    exp_v = model_out();
    got_v = dut_out();
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL cycle_model t=%0t: got %03h expected %03h", $time, got_v, exp_v);
    end
  end

  task automatic drive(input logic r, input logic sc, input logic lu, input logic br,
                       input logic md, input logic dn);
    @(negedge CLOCK);
    RESET               = r;
    bus.Syscall_IN      = sc;
    bus.LoadUse_IN      = lu;
    bus.Branch_Taken_IN = br;
    bus.MulDiv_Start_IN = md;
    bus.Syscall_Done_IN = dn;
  endtask

  // Drive one cycle and pin both the DUT and the model to a hand-computed value
  task automatic step(input logic r, input logic sc, input logic lu, input logic br,
                      input logic md, input logic dn, input logic [11:0] exp_v, input string nm);
    logic [11:0] got_v, mod_v;
    drive(r, sc, lu, br, md, dn);
    #2;
    got_v = dut_out();
    mod_v = model_out();
    n_vec += 2;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s (dut) t=%0t: got %03h expected %03h", nm, $time, got_v, exp_v);
    end
    if (mod_v !== exp_v) begin
      n_err++;
      $display("FAIL %s (model) t=%0t: got %03h expected %03h", nm, $time, mod_v, exp_v);
    end
  endtask

  initial begin
    bus.Syscall_IN = 1'b0; bus.LoadUse_IN = 1'b0; bus.Branch_Taken_IN = 1'b0;
    bus.MulDiv_Start_IN = 1'b0; bus.Syscall_Done_IN = 1'b0;

    for (int i = 0; i < 4; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), O_NONE, "reset_hold");
    step(1'b1, 0, 0, 0, 0, 0, O_NONE, "reset_release");

    step(1'b1, 0, 1, 1, 0, 0, O_LU,   "loaduse_plus_branch");
    step(1'b1, 0, 0, 0, 0, 0, O_NONE, "loaduse_one_bubble");
    step(1'b1, 0, 0, 1, 0, 0, O_BR,   "branch_flush");
    step(1'b1, 0, 0, 0, 0, 1, O_NONE, "done_in_run_ignored");

    // Mult/div with syscall held behind it
    step(1'b1, 1, 0, 0, 1, 0, O_MD,         "muldiv_start");
    step(1'b1, 1, 0, 0, 0, 0, O_MD | 12'd1, "muldiv_stall2");
    step(1'b1, 1, 1, 1, 0, 0, O_MD | 12'd1, "muldiv_stall3");
    step(1'b1, 1, 0, 0, 0, 0, O_SC,         "syscall_after_muldiv");
    step(1'b1, 0, 0, 0, 0, 1, O_SC | 12'd2, "drain1");
    step(1'b1, 0, 1, 0, 1, 0, O_SC | 12'd2, "drain2");
    step(1'b1, 0, 0, 0, 0, 0, O_SC | 12'd2, "drain3");
    step(1'b1, 0, 0, 0, 0, 0, O_SC | 12'd7, "service_pulse");
    step(1'b1, 0, 0, 0, 0, 0, O_SC | 12'd3, "service_wait");
    step(1'b1, 0, 0, 0, 0, 1, O_SC | 12'd3, "service_done");
    step(1'b1, 0, 0, 0, 0, 0, O_NONE,       "back_to_run");

    // Reset in DRAIN with two cycles left
    step(1'b1, 1, 0, 0, 0, 0, O_SC,         "syscall2");
    step(1'b1, 0, 0, 0, 0, 0, O_SC | 12'd2, "drain_cnt3");
    step(1'b0, 0, 0, 0, 0, 0, O_NONE,       "reset_mid_drain");
    step(1'b1, 0, 0, 0, 0, 0, O_NONE,       "after_reset_run");
    step(1'b1, 0, 0, 0, 0, 0, O_NONE,       "no_stale_pulse");
    step(1'b1, 1, 0, 0, 0, 0, O_SC,         "syscall3");
    step(1'b1, 0, 0, 0, 0, 0, O_SC | 12'd2, "full_drain1");
    step(1'b1, 0, 0, 0, 0, 0, O_SC | 12'd2, "full_drain2");
    step(1'b1, 0, 0, 0, 0, 0, O_SC | 12'd2, "full_drain3");
    step(1'b1, 0, 0, 0, 0, 1, O_SC | 12'd7, "done_with_pulse");
    step(1'b1, 0, 0, 0, 0, 0, O_NONE,       "run_after_fast_done");

    // Reset during mult/div
    step(1'b1, 0, 0, 0, 1, 0, O_MD,         "muldiv_start2");
    step(1'b0, 0, 0, 0, 0, 0, O_NONE,       "reset_mid_muldiv");
    step(1'b1, 0, 0, 0, 0, 0, O_NONE,       "run_after_muldiv_reset");

    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 2) == 0));

    @(negedge CLOCK);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
